fg_prefetch_scheduler: RTL and testbench

//  Sequences the foreground object-scanline prefetch unit. Converts per-scanline video timing events

---
 rtl/fg_prefetch_scheduler.sv | 123 ++++++++++++
 tb/tb_fg_prefetch_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_prefetch_scheduler.sv
// Turns per-scanline timing events into queued foreground prefetch requests and issues
// them one at a time, only while the foreground prefetch unit is idle.
module fg_prefetch_scheduler #(
  parameter int PREFETCH_SCANLINES = 1,
  parameter int VISIBLE_LINES      = 240,
  parameter int TOTAL_LINES        = 262,
  parameter int QUEUE_DEPTH        = 2
) (
  input  logic                               gpu_clk,
  input  logic                               rst,
  input  logic                               enable_i,
  input  logic                               line_start_i,
  input  logic [8:0]                         line_y_i,
  input  logic                               prefetch_busy_i,
  output logic                               prefetch_start_o,
  output logic [7:0]                         prefetch_y_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level_o,
  output logic                               overrun_o,
  output logic [7:0]                         missed_count_o,
  input  logic                               clear_overrun_i
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = $clog2(QUEUE_DEPTH+1);

  typedef enum logic [1:0] {IDLE, GUARD, WAIT} state_t;

  state_t             state_reg;
  logic               start_reg;
  logic [7:0]         y_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               overrun_reg;
  logic [7:0]         missed_reg;

  logic [9:0]         sum;
  logic [8:0]         target;
  logic               req_valid;
  logic               q_full;
  logic               q_empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic [7:0]         slot_q [QUEUE_DEPTH];

  // Lookahead target wraps once per frame; lines past the visible area are never requested.
  assign sum       = {1'b0, line_y_i} + 10'(PREFETCH_SCANLINES);
  assign target    = (sum >= 10'(TOTAL_LINES)) ? 9'(sum - 10'(TOTAL_LINES)) : sum[8:0];
  assign req_valid = line_start_i && enable_i && (target < 9'(VISIBLE_LINES));

  assign q_full  = (level_reg == LVL_W'(QUEUE_DEPTH));
  assign q_empty = (level_reg == '0);
  assign pop     = (state_reg == IDLE) && !q_empty && !prefetch_busy_i && enable_i;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push    = req_valid && (!q_full || pop);
  assign drop    = req_valid && q_full && !pop;

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
    logic [7:0] slot_reg;
    always_ff @(posedge gpu_clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        slot_reg <= target[7:0];
      end
    end
    assign slot_q[gi] = slot_reg;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_reg   <= 1'b0;
      y_reg       <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
      missed_reg  <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            start_reg <= 1'b1;
            y_reg     <= slot_q[rd_ptr_reg];
            state_reg <= GUARD;
          end
        end
        // Foreground sees the start one cycle late, so busy is not yet meaningful here.
        GUARD:   state_reg <= WAIT;
        WAIT:    if (!prefetch_busy_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (!enable_i) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (push && !pop)      level_reg <= level_reg + 1'b1;
        else if (pop && !push) level_reg <= level_reg - 1'b1;
      end

      if (drop) begin
        overrun_reg <= 1'b1;
        if (clear_overrun_i)         missed_reg <= 8'd1;
        else if (missed_reg != 8'hFF) missed_reg <= missed_reg + 8'd1;
      end else if (clear_overrun_i) begin
        overrun_reg <= 1'b0;
        missed_reg  <= '0;
      end
    end
  end

  assign prefetch_start_o = start_reg;
  assign prefetch_y_o     = y_reg;
  assign queue_level_o    = level_reg;
  assign overrun_o        = overrun_reg;
  assign missed_count_o   = missed_reg;

endmodule

// File: tb/tb_fg_prefetch_scheduler.sv
// Self-checking bench for fg_prefetch_scheduler: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the scheduling rules.
module tb_fg_prefetch_scheduler;

  localparam int P     = 1;
  localparam int VIS   = 240;
  localparam int TOT   = 262;
  localparam int DEPTH = 2;

  logic       gpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = '0;
  logic       busy = 1'b0;
  logic       clr = 1'b0;
  logic       prefetch_start;
  logic [7:0] prefetch_y;
  logic [1:0] queue_level;
  logic       overrun;
  logic [7:0] missed_count;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  fg_prefetch_scheduler #(
    .PREFETCH_SCANLINES(P), .VISIBLE_LINES(VIS), .TOTAL_LINES(TOT), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .gpu_clk(gpu_clk),
    .rst(rst),
    .enable_i(enable),
    .line_start_i(line_start),
    .line_y_i(line_y),
    .prefetch_busy_i(busy),
    .prefetch_start_o(prefetch_start),
    .prefetch_y_o(prefetch_y),
    .queue_level_o(queue_level),
    .overrun_o(overrun),
    .missed_count_o(missed_count),
    .clear_overrun_i(clr)
  );

  always #5 gpu_clk = ~gpu_clk;

  // Behavioural model: pending requests in a queue, in-flight phase as a small counter.
  int  mq[$];
  int  m_phase;
  bit  m_start;
  int  m_y;
  bit  m_ovr;
  int  m_missed;

  initial begin
    int t;
    bit req, issue, lost;
    m_phase = 0; m_start = 0; m_y = 0; m_ovr = 0; m_missed = 0;
    forever begin
      @(posedge gpu_clk);
      if (rst) begin
        mq.delete();
        m_phase = 0; m_start = 0; m_y = 0; m_ovr = 0; m_missed = 0;
      end else begin
        t = int'(line_y) + P;
        if (t >= TOT) t -= TOT;
        req   = line_start && enable && (t < VIS);
        issue = (m_phase == 0) && (mq.size() != 0) && !busy && enable;
        lost  = req && !issue && (mq.size() == DEPTH);
        m_start = issue;
        if (m_phase == 0)      m_phase = issue ? 1 : 0;
        else if (m_phase == 1) m_phase = 2;
        else if (!busy)        m_phase = 0;
        if (issue) m_y = mq.pop_front();
        if (!enable) mq.delete();
        else if (req && !lost) mq.push_back(t);
        if (lost) begin
          m_ovr = 1;
          m_missed = clr ? 1 : ((m_missed < 255) ? m_missed + 1 : 255);
        end else if (clr) begin
          m_ovr = 0;
          m_missed = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge gpu_clk);
      if (mon_en && !rst) begin
        total++;
        if (prefetch_start !== m_start) begin
          bad++;
          $display("FAIL mon_start t=%0t: got %0d expected %0d", $time, prefetch_start, m_start);
        end
        total++;
        if (prefetch_y !== 8'(m_y)) begin
          bad++;
          $display("FAIL mon_y t=%0t: got %0d expected %0d", $time, prefetch_y, m_y);
        end
        total++;
        if (queue_level !== 2'(mq.size())) begin
          bad++;
          $display("FAIL mon_level t=%0t: got %0d expected %0d", $time, queue_level, mq.size());
        end
        total++;
        if (overrun !== m_ovr || missed_count !== 8'(m_missed)) begin
          bad++;
          $display("FAIL mon_overrun t=%0t: got %0d/%0d expected %0d/%0d",
                   $time, overrun, missed_count, m_ovr, m_missed);
        end
      end
    end
  end

  task automatic step();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int y);
    line_y = 9'(y);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    steps(3);
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    total++;
    if (prefetch_start !== 1'b0 || prefetch_y !== 8'd0 || queue_level !== 2'd0 ||
        overrun !== 1'b0 || missed_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%0d y=%0d lvl=%0d ovr=%0d miss=%0d expected all 0",
               prefetch_start, prefetch_y, queue_level, overrun, missed_count);
    end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    busy = 1'b0;
    send(9);
    total++;
    if (queue_level !== 2'd1 || prefetch_start !== 1'b0) begin
      bad++;
      $display("FAIL basic_queued: got lvl=%0d start=%0d expected lvl=1 start=0", queue_level, prefetch_start);
    end
    step();
    total++;
    if (prefetch_start !== 1'b1 || prefetch_y !== 8'd10 || queue_level !== 2'd0) begin
      bad++;
      $display("FAIL basic_issue: got start=%0d y=%0d lvl=%0d expected 1/10/0",
               prefetch_start, prefetch_y, queue_level);
    end
    step();
    total++;
    if (prefetch_start !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse_width: got %0d expected 0", prefetch_start);
    end
    steps(2);
  endtask

  task automatic test_wrap();
    send(261);
    step();
    total++;
    if (prefetch_start !== 1'b1 || prefetch_y !== 8'd0) begin
      bad++;
      $display("FAIL wrap_261: got start=%0d y=%0d expected 1/0", prefetch_start, prefetch_y);
    end
    steps(3);
    send(239);
    total++;
    if (queue_level !== 2'd0) begin
      bad++;
      $display("FAIL no_req_239: got lvl=%0d expected 0", queue_level);
    end
    send(260);
    step();
    total++;
    if (queue_level !== 2'd0 || prefetch_start !== 1'b0 || prefetch_y !== 8'd0) begin
      bad++;
      $display("FAIL no_req_260: got lvl=%0d start=%0d y=%0d expected 0/0/0",
               queue_level, prefetch_start, prefetch_y);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    clr = 1'b1;
    step();
    clr = 1'b0;
    busy = 1'b1;
    pulses = 0;
    send(5);  step();
    send(6);  step();
    send(7);
    for (int i = 0; i < 95; i++) begin
      if (prefetch_start) pulses++;
      step();
    end
    total++;
    if (queue_level !== 2'd2 || overrun !== 1'b1 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL overrun_drop: got lvl=%0d ovr=%0d miss=%0d expected 2/1/1",
               queue_level, overrun, missed_count);
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL overrun_no_issue: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_full_pop();
    int got[$];
    busy = 1'b0;
    line_y = 9'd20;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    total++;
    if (queue_level !== 2'd2 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL full_pop_level: got lvl=%0d miss=%0d expected 2/1", queue_level, missed_count);
    end
    for (int i = 0; i < 40; i++) begin
      if (prefetch_start) got.push_back(int'(prefetch_y));
      step();
    end
    total++;
    if (got.size() != 3 || got[0] != 6 || got[1] != 7 || got[2] != 21) begin
      bad++;
      $display("FAIL full_pop_order: got %p expected '{6,7,21}", got);
    end
  endtask

  task automatic test_clear_drop();
    busy = 1'b1;
    send(50);
    send(51);
    clr = 1'b1;
    send(52);
    clr = 1'b0;
    total++;
    if (overrun !== 1'b1 || missed_count !== 8'd1) begin
      bad++;
      $display("FAIL drop_vs_clear: got ovr=%0d miss=%0d expected 1/1", overrun, missed_count);
    end
    line_y = 9'd60;
    line_start = 1'b1;
    steps(300);
    line_start = 1'b0;
    total++;
    if (overrun !== 1'b1 || missed_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate: got ovr=%0d miss=%0d expected 1/255", overrun, missed_count);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || missed_count !== 8'd0) begin
      bad++;
      $display("FAIL clear: got ovr=%0d miss=%0d expected 0/0", overrun, missed_count);
    end
    enable = 1'b0;
    step();
    enable = 1'b1;
    busy = 1'b0;
    steps(2);
  endtask

  task automatic test_enable_low();
    int pulses;
    bit seen;
    busy = 1'b0;
    send(30);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (prefetch_start) seen = 1'b1;
      else step();
    end
    total++;
    if (!seen || prefetch_y !== 8'd31) begin
      bad++;
      $display("FAIL en_flight_issue: got seen=%0d y=%0d expected 1/31", seen, prefetch_y);
    end
    busy = 1'b1;
    send(40);
    send(41);
    total++;
    if (queue_level !== 2'd2) begin
      bad++;
      $display("FAIL en_queued: got lvl=%0d expected 2", queue_level);
    end
    enable = 1'b0;
    step();
    total++;
    if (queue_level !== 2'd0) begin
      bad++;
      $display("FAIL en_flush: got lvl=%0d expected 0", queue_level);
    end
    steps(5);
    busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (prefetch_start) pulses++;
    end
    total++;
    if (pulses !== 0 || queue_level !== 2'd0 || prefetch_y !== 8'd31) begin
      bad++;
      $display("FAIL en_quiet: got pulses=%0d lvl=%0d y=%0d expected 0/0/31", pulses, queue_level, prefetch_y);
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    busy = 1'b0;
    send(100);
    step();
    busy = 1'b1;
    send(101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy = 1'b0;
    total++;
    if (prefetch_start !== 1'b0 || prefetch_y !== 8'd0 || queue_level !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: got start=%0d y=%0d lvl=%0d expected 0/0/0",
               prefetch_start, prefetch_y, queue_level);
    end
    step();
  endtask

  task automatic test_random();
    int edge_y[6] = '{238, 239, 240, 260, 261, 0};
    for (int i = 0; i < 1500; i++) begin
      line_start = ($urandom_range(0, 2) == 0);
      line_y = ($urandom_range(0, 4) == 0) ? 9'(edge_y[$urandom_range(0, 5)]) : 9'($urandom_range(0, TOT - 1));
      if ($urandom_range(0, 3) == 0) busy = ~busy;
      enable = ($urandom_range(0, 29) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step();
    end
    line_start = 1'b0;
    enable = 1'b1;
    clr = 1'b0;
    busy = 1'b0;
    steps(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_full_pop();
    test_clear_drop();
    test_enable_low();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
